cart_mem_arbiter: RTL and testbench

Shares the single external cartridge SRAM between the Game Boy cartridge bus, already translated by the MBC into a flat ROM/RAM address, and the host loader port that fills ROM images and backs up save RAM. Sequences every SRAM cycle: arbitration, strobe timing, read-data capture, completion handshake. Sits between the MBC address translation and the SRAM pins. GB accesses take priority; the host port uses the remaining slots.

---
 rtl/cart_arb_pkg.sv | 19 +
 rtl/cart_arb_starve_ctr.sv | 37 +++
 rtl/cart_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cart_arb_pkg.sv
// Shared types and the address-map helper for the cartridge SRAM arbiter.
package cart_arb_pkg;

    localparam int unsigned ADR_W      = 22;
    localparam int unsigned SRAM_ADR_W = 21;
    localparam int unsigned RAM_BIT    = 21;

    typedef enum logic [1:0] {StIdle, StAcc, StRecover} arb_state_e;
    typedef enum logic {OwnGb, OwnHost} arb_owner_e;

    // ROM occupies the low 2 MiB; save RAM is folded onto the top 128 KiB.
    function automatic logic [SRAM_ADR_W-1:0] map_adr(input logic [ADR_W-1:0] adr);
        if (adr[RAM_BIT]) begin
            return {4'b1111, adr[16:0]};
        end
        return adr[SRAM_ADR_W-1:0];
    endfunction

endpackage

// File: rtl/cart_arb_starve_ctr.sv
// Saturating count of GB grants taken while the host waits; force_host at the limit.
module cart_arb_starve_ctr
    import cart_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic force_host
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(STARVE_MAX))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_host = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge SRAM between the GB bus and the host loader; GB has priority.
// Define CART_ARB_STARVE_GUARD_EN to let a starved host through after STARVE_MAX GB grants.
module cart_mem_arbiter
    import cart_arb_pkg::*;
#(
    parameter int unsigned ACC_CYCLES = 2
`ifdef CART_ARB_STARVE_GUARD_EN
    , parameter int unsigned STARVE_MAX = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gb_req,
    input  logic                  gb_we,
    input  logic [ADR_W-1:0]      gb_adr,
    input  logic [7:0]            gb_wdata,
    output logic [7:0]            gb_rdata,
    output logic                  gb_done,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADR_W-1:0]      host_adr,
    input  logic [7:0]            host_wdata,
    output logic [7:0]            host_rdata,
    output logic                  host_ack,
    output logic [SRAM_ADR_W-1:0] sram_adr,
    output logic [7:0]            sram_dq_o,
    output logic                  sram_dq_oe,
    input  logic [7:0]            sram_dq_i,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam int unsigned CNT_W = $clog2(ACC_CYCLES + 1);

    arb_state_e            state_q, state_d;
    arb_owner_e            owner_q, owner_d;
    logic                  we_q, we_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [SRAM_ADR_W-1:0] adr_d;
    logic [7:0]            dq_o_d, gb_rdata_d, host_rdata_d;
    logic                  dq_oe_d, ce_n_d, oe_n_d, we_n_d, gb_done_d, host_ack_d;

    logic                  idle, take_gb, take_host, sel_we;
    logic [ADR_W-1:0]      sel_adr;
    logic [7:0]            sel_wdata;

    assign idle = (state_q == StIdle);

`ifdef CART_ARB_STARVE_GUARD_EN
    logic force_host;

    assign take_host = idle && host_req && (!gb_req || force_host);
    assign take_gb   = idle && gb_req && !take_host;

    cart_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk        (clk),
        .reset      (reset),
        .clr        (take_host || (idle && !host_req)),
        .inc        (take_gb && host_req),
        .force_host (force_host)
    );
`else
    assign take_gb   = idle && gb_req;
    assign take_host = idle && host_req && !gb_req;
`endif

    assign sel_we    = take_gb ? gb_we    : host_we;
    assign sel_adr   = take_gb ? gb_adr   : host_adr;
    assign sel_wdata = take_gb ? gb_wdata : host_wdata;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        adr_d        = sram_adr;
        dq_o_d       = sram_dq_o;
        dq_oe_d      = sram_dq_oe;
        ce_n_d       = sram_ce_n;
        oe_n_d       = sram_oe_n;
        we_n_d       = sram_we_n;
        gb_done_d    = 1'b0;
        host_ack_d   = 1'b0;
        gb_rdata_d   = gb_rdata;
        host_rdata_d = host_rdata;

        unique case (state_q)
            StIdle: begin
                if (take_gb || take_host) begin
                    state_d = StAcc;
                    owner_d = take_gb ? OwnGb : OwnHost;
                    we_d    = sel_we;
                    cnt_d   = CNT_W'(ACC_CYCLES);
                    adr_d   = map_adr(sel_adr);
                    dq_o_d  = sel_wdata;
                    ce_n_d  = 1'b0;
                    oe_n_d  = sel_we;
                    we_n_d  = !sel_we;
                    dq_oe_d = sel_we;
                end
            end
            StAcc: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StRecover;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    // Write data stays driven through recovery for hold time.
                    dq_oe_d = we_q;
                    if (owner_q == OwnGb) begin
                        gb_done_d = 1'b1;
                        if (!we_q) gb_rdata_d = sram_dq_i;
                    end else begin
                        host_ack_d = 1'b1;
                        if (!we_q) host_rdata_d = sram_dq_i;
                    end
                end
            end
            StRecover: begin
                state_d = StIdle;
                dq_oe_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= OwnGb;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            sram_adr   <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            gb_done    <= 1'b0;
            host_ack   <= 1'b0;
            gb_rdata   <= '0;
            host_rdata <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            sram_adr   <= adr_d;
            sram_dq_o  <= dq_o_d;
            sram_dq_oe <= dq_oe_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            gb_done    <= gb_done_d;
            host_ack   <= host_ack_d;
            gb_rdata   <= gb_rdata_d;
            host_rdata <= host_rdata_d;
        end
    end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter with ACC_CYCLES=2; expectations are hand-computed.
module tb_cart_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        gb_req = 1'b0, gb_we = 1'b0;
    logic [21:0] gb_adr = '0;
    logic [7:0]  gb_wdata = '0;
    logic [7:0]  gb_rdata;
    logic        gb_done;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [21:0] host_adr = '0;
    logic [7:0]  host_wdata = '0;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic [20:0] sram_adr;
    logic [7:0]  sram_dq_o;
    logic        sram_dq_oe;
    logic [7:0]  rd_val = '0;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    int n_checks = 0;
    int n_errors = 0;

    // Activity monitor, sampled mid-cycle.
    int   acc_cnt = 0, we_low_cnt = 0, done_cnt = 0, ack_cnt = 0;
    logic ce_prev = 1'b1;

    cart_mem_arbiter #(
        .ACC_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gb_req     (gb_req),
        .gb_we      (gb_we),
        .gb_adr     (gb_adr),
        .gb_wdata   (gb_wdata),
        .gb_rdata   (gb_rdata),
        .gb_done    (gb_done),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_adr   (host_adr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .sram_adr   (sram_adr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (rd_val),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ce_prev === 1'b1 && sram_ce_n === 1'b0) acc_cnt <= acc_cnt + 1;
        if (sram_we_n === 1'b0) we_low_cnt <= we_low_cnt + 1;
        if (gb_done === 1'b1) done_cnt <= done_cnt + 1;
        if (host_ack === 1'b1) ack_cnt <= ack_cnt + 1;
        ce_prev <= sram_ce_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int a0, w0, d0, k0;
    logic guard;

    initial begin
`ifdef CART_ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        tick(); tick();
        check_eq("rst_ce_n", 32'(sram_ce_n), 32'h1);
        check_eq("rst_oe_n", 32'(sram_oe_n), 32'h1);
        check_eq("rst_we_n", 32'(sram_we_n), 32'h1);
        check_eq("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        check_eq("rst_adr", 32'(sram_adr), 32'h0);
        check_eq("rst_dq_o", 32'(sram_dq_o), 32'h0);
        check_eq("rst_done_ack", 32'({gb_done, host_ack}), 32'h0);
        check_eq("rst_rdata", 32'({gb_rdata, host_rdata}), 32'h0);
        reset = 1'b0;
        tick();

        // Host write 0x5A to 0x000123, held past ack, dropped the cycle after.
        a0 = acc_cnt; w0 = we_low_cnt; k0 = ack_cnt;
        host_req = 1'b1; host_we = 1'b1; host_adr = 22'h000123; host_wdata = 8'h5A;
        tick();
        check_eq("hw1_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b0101);
        check_eq("hw1_adr", 32'(sram_adr), 32'h000123);
        check_eq("hw1_dq_o", 32'(sram_dq_o), 32'h5A);
        check_eq("hw1_ack", 32'(host_ack), 32'h0);
        tick();
        check_eq("hw2_we_n", 32'(sram_we_n), 32'h0);
        check_eq("hw2_ack", 32'(host_ack), 32'h0);
        tick();
        check_eq("hw3_ack", 32'(host_ack), 32'h1);
        check_eq("hw3_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b1111);
        check_eq("hw3_adr_hold", 32'(sram_adr), 32'h000123);
        tick();
        check_eq("hw4_ack", 32'(host_ack), 32'h0);
        check_eq("hw4_dq_oe", 32'(sram_dq_oe), 32'h0);
        host_req = 1'b0;
        tick(); tick(); tick();
        check_eq("hw_accesses", 32'(acc_cnt - a0), 32'd1);
        check_eq("hw_we_low_cycles", 32'(we_low_cnt - w0), 32'd2);
        check_eq("hw_ack_pulses", 32'(ack_cnt - k0), 32'd1);

        // GB read from RAM region 0x200010.
        gb_req = 1'b1; gb_we = 1'b0; gb_adr = 22'h200010; rd_val = 8'hC3;
        tick();
        check_eq("gr1_adr", 32'(sram_adr), 32'h1E0010);
        check_eq("gr1_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b0010);
        tick(); tick();
        check_eq("gr3_done", 32'(gb_done), 32'h1);
        check_eq("gr3_rdata", 32'(gb_rdata), 32'hC3);
        tick();
        gb_req = 1'b0; rd_val = 8'h00;
        check_eq("gr4_done", 32'(gb_done), 32'h0);
        tick(); tick();
        check_eq("gr_rdata_held", 32'(gb_rdata), 32'hC3);
        check_eq("gr_host_rdata", 32'(host_rdata), 32'h0);

        // Simultaneous requests: GB first, then host.
        d0 = done_cnt; k0 = ack_cnt;
        gb_req = 1'b1; gb_adr = 22'h000055; rd_val = 8'h11;
        host_req = 1'b1; host_we = 1'b0; host_adr = 22'h000077;
        tick();
        check_eq("sim_first_adr", 32'(sram_adr), 32'h000055);
        tick(); tick();
        check_eq("sim_gb_done", 32'({gb_done, host_ack}), 32'b10);
        check_eq("sim_gb_rdata", 32'(gb_rdata), 32'h11);
        tick();
        gb_req = 1'b0; rd_val = 8'h22;
        tick();
        check_eq("sim_second_adr", 32'(sram_adr), 32'h000077);
        tick(); tick();
        check_eq("sim_host_ack", 32'({gb_done, host_ack}), 32'b01);
        check_eq("sim_host_rdata", 32'(host_rdata), 32'h22);
        tick();
        host_req = 1'b0;
        tick(); tick();
        check_eq("sim_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_eq("sim_ack_pulses", 32'(ack_cnt - k0), 32'd1);

        // GB saturates the bus while the host waits.
        gb_req = 1'b1; gb_we = 1'b0; gb_adr = 22'h000100;
        host_req = 1'b1; host_we = 1'b0; host_adr = 22'h000200;
        for (int k = 0; k < 10; k++) begin
            logic exp_host;
            exp_host = guard && (k == 8);
            tick();
            check_eq($sformatf("starve_grant%0d", k), 32'(sram_adr),
                     exp_host ? 32'h000200 : 32'h000100);
            tick(); tick(); tick();
            if (exp_host) host_req = 1'b0;
        end
        gb_req = 1'b0; host_req = 1'b0;
        tick(); tick(); tick(); tick();
        check_eq("starve_idle_ce_n", 32'(sram_ce_n), 32'h1);

        // Reset during the second ACC cycle of a GB write.
        d0 = done_cnt;
        gb_req = 1'b1; gb_we = 1'b1; gb_adr = 22'h000300; gb_wdata = 8'h99;
        tick();
        tick();
        check_eq("rw_acc2_we_n", 32'(sram_we_n), 32'h0);
        reset = 1'b1; gb_req = 1'b0;
        tick();
        check_eq("rw_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b1110);
        check_eq("rw_done", 32'(gb_done), 32'h0);
        check_eq("rw_adr", 32'(sram_adr), 32'h0);
        check_eq("rw_gb_rdata", 32'(gb_rdata), 32'h0);
        reset = 1'b0;
        tick(); tick(); tick();
        check_eq("rw_no_done", 32'(done_cnt - d0), 32'd0);

        // Fresh host read after reset.
        host_req = 1'b1; host_we = 1'b0; host_adr = 22'h200005; rd_val = 8'h7E;
        tick();
        check_eq("pr_adr", 32'(sram_adr), 32'h1E0005);
        tick(); tick();
        check_eq("pr_ack", 32'(host_ack), 32'h1);
        check_eq("pr_rdata", 32'(host_rdata), 32'h7E);
        tick();
        host_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
